hpdcache_flush_seq: RTL

Whole-cache flush sequencer for the HPDcache. On a single request it walks every set of the cache directory and reads the dirty bits and tags. It pushes one allocation per dirty line into the flush controller's ALLOC interface and clears each dirty bit as the allocation is accepted. It then waits for the flush controller to drain before signalling completion. It sits between the core's fence/flush-all command path, the directory arbitration port of the cache controller, and the flush controller.

---
 rtl/hpdcache_flush_seq_pkg.sv | 26 ++
 rtl/hpdcache_prio_1hot_encoder.sv | 28 ++
 rtl/hpdcache_flush_seq.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/hpdcache_flush_seq_pkg.sv
// Shared types for the HPDcache whole-cache flush sequencer: FSM encoding,
// default cache geometry and the set/nline types derived from it.
package hpdcache_flush_seq_pkg;

  typedef enum logic [2:0] {
    FS_IDLE,
    FS_READ,
    FS_LATCH,
    FS_ISSUE,
    FS_DRAIN
  } hpdcache_flush_seq_fsm_e;

  // Index width that never collapses to zero bits for single-entry structures.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned HPDCACHE_SETS      = 64;
  localparam int unsigned HPDCACHE_WAYS      = 4;
  localparam int unsigned HPDCACHE_TAG_WIDTH = 20;
  localparam int unsigned HPDCACHE_SET_WIDTH = clog2_min1(HPDCACHE_SETS);

  typedef logic [HPDCACHE_SET_WIDTH-1:0]                    hpdcache_set_t;
  typedef logic [HPDCACHE_TAG_WIDTH+HPDCACHE_SET_WIDTH-1:0] hpdcache_nline_t;

endpackage

// File: rtl/hpdcache_prio_1hot_encoder.sv
// Priority encoder: lowest-index set bit of val_i as a one-hot vector and a
// binary index. Both outputs are zero when val_i is zero.
module hpdcache_prio_1hot_encoder
  import hpdcache_flush_seq_pkg::*;
#(
  parameter  int unsigned N    = 4,
  localparam int unsigned IdxW = clog2_min1(N)
) (
  input  logic [N-1:0]    val_i,
  output logic [N-1:0]    onehot_o,
  output logic [IdxW-1:0] idx_o
);

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves a
    // value unassigned and no latch is inferred.
    onehot_o = '0;
    idx_o    = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (val_i[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        idx_o       = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/hpdcache_flush_seq.sv
// HPDcache whole-cache flush sequencer: walks every directory set, hands each
// dirty line to the flush controller, then waits for it to drain.
// Optional line counter output enabled by HPDCACHE_FLUSH_SEQ_CNT_EN.
module hpdcache_flush_seq
  import hpdcache_flush_seq_pkg::*;
#(
  parameter  int unsigned Sets     = 64,
  parameter  int unsigned Ways     = 4,
  parameter  int unsigned TagWidth = 20,
  localparam int unsigned SetW     = clog2_min1(Sets),
  localparam int unsigned WayIdxW  = clog2_min1(Ways),
  localparam int unsigned NlineW   = TagWidth + SetW
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_req_valid_i,
  output logic                     flush_req_ready_o,
  output logic                     flush_done_o,
  output logic                     busy_o,
  output logic                     dir_rd_o,
  output logic [SetW-1:0]          dir_rd_set_o,
  input  logic                     dir_rd_gnt_i,
  input  logic [Ways-1:0]          dir_dirty_i,
  input  logic [Ways*TagWidth-1:0] dir_tag_i,
  output logic                     dir_clr_o,
  output logic [SetW-1:0]          dir_clr_set_o,
  output logic [Ways-1:0]          dir_clr_way_o,
  output logic                     flush_alloc_o,
  input  logic                     flush_alloc_ready_i,
  output logic [NlineW-1:0]        flush_alloc_nline_o,
  output logic [Ways-1:0]          flush_alloc_way_o,
  input  logic                     flush_empty_i
`ifdef HPDCACHE_FLUSH_SEQ_CNT_EN
  ,
  output logic [15:0]              flush_cnt_o
`endif
);

  localparam logic [SetW-1:0] LastSet = SetW'(Sets - 1);

  hpdcache_flush_seq_fsm_e state_q, state_d;
  logic [SetW-1:0]     set_q, set_d;
  logic [Ways-1:0]     dirty_q, dirty_d;
  logic [TagWidth-1:0] tag_q [Ways];

  logic [Ways-1:0]    way_1hot;
  logic [WayIdxW-1:0] way_idx;
  logic               req_accept;
  logic               alloc_accept;

  hpdcache_prio_1hot_encoder #(.N(Ways)) u_way_sel (
    .val_i    (dirty_q),
    .onehot_o (way_1hot),
    .idx_o    (way_idx)
  );

  always_comb begin
    state_d             = state_q;
    set_d               = set_q;
    dirty_d             = dirty_q;
    flush_req_ready_o   = 1'b0;
    flush_done_o        = 1'b0;
    dir_rd_o            = 1'b0;
    dir_rd_set_o        = '0;
    dir_clr_o           = 1'b0;
    dir_clr_set_o       = '0;
    dir_clr_way_o       = '0;
    flush_alloc_o       = 1'b0;
    flush_alloc_nline_o = '0;
    flush_alloc_way_o   = '0;

    unique case (state_q)
      FS_IDLE: begin
        flush_req_ready_o = 1'b1;
        if (flush_req_valid_i) begin
          set_d   = '0;
          state_d = FS_READ;
        end
      end
      FS_READ: begin
        dir_rd_o     = 1'b1;
        dir_rd_set_o = set_q;
        if (dir_rd_gnt_i) state_d = FS_LATCH;
      end
      FS_LATCH: begin
        dirty_d = dir_dirty_i;
        state_d = FS_ISSUE;
      end
      FS_ISSUE: begin
        if (|dirty_q) begin
          flush_alloc_o       = 1'b1;
          flush_alloc_nline_o = {tag_q[way_idx], set_q};
          flush_alloc_way_o   = way_1hot;
          if (flush_alloc_ready_i) begin
            dir_clr_o     = 1'b1;
            dir_clr_set_o = set_q;
            dir_clr_way_o = way_1hot;
            dirty_d       = dirty_q & ~way_1hot;
          end
        end else if (set_q == LastSet) begin
          state_d = FS_DRAIN;
        end else begin
          set_d   = set_q + SetW'(1);
          state_d = FS_READ;
        end
      end
      FS_DRAIN: begin
        if (flush_empty_i) begin
          flush_done_o = 1'b1;
          state_d      = FS_IDLE;
        end
      end
      default: state_d = FS_IDLE;
    endcase
  end

  assign busy_o       = (state_q != FS_IDLE);
  assign req_accept   = flush_req_ready_o & flush_req_valid_i;
  assign alloc_accept = flush_alloc_o & flush_alloc_ready_i;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FS_IDLE;
      set_q   <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      dirty_q <= dirty_d;
    end
  end

  // NOTE: tags are only consumed under a non-zero dirty_q, so this data array
  // needs no reset.
  always_ff @(posedge clk_i) begin
    if (state_q == FS_LATCH) begin
      for (int w = 0; w < int'(Ways); w++) begin
        tag_q[w] <= dir_tag_i[w*TagWidth +: TagWidth];
      end
    end
  end

`ifdef HPDCACHE_FLUSH_SEQ_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || req_accept) begin
      cnt_q <= '0;
    end else if (alloc_accept && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign flush_cnt_o = cnt_q;
`else
  // Without the counter the accept strobes have no consumer.
  logic unused_strobes;
  assign unused_strobes = req_accept ^ alloc_accept;
`endif

endmodule
